// File: rtl/sync_fifo_param_if.sv
// Handshake/data bundle between a synchronous FIFO and its user.
// The master side pushes/pops and clears errors; the slave side is the FIFO.
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  logic                     wr_en;
  logic [WIDTH-1:0]         wr_data;
  logic                     rd_en;
  logic [WIDTH-1:0]         rd_data;
  logic                     full;
  logic                     almost_full;
  logic                     empty;
  logic                     almost_empty;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;
  logic                     underflow;
  logic                     clr_err;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, full, almost_full, empty, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, full, almost_full, empty, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with registered status flags, sticky overflow/underflow
// error flags and a selectable registered or first-word-fall-through read.
// Reset is synchronous and active-low; the storage array itself is never
// cleared, only pointers, occupancy, flags and the read register.
module sync_fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = 0
) (
  input logic       clk,
  input logic       rst,
  sync_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] C_AE    = CW'(AE_LEVEL);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_almost_full;
  logic             r_empty;
  logic             r_almost_empty;
  logic             r_overflow;
  logic             r_underflow;
  logic [WIDTH-1:0] r_rd_data;

  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_wr_rej;
  logic             w_rd_rej;
  logic [CW-1:0]    w_count_nxt;

  // Acceptance decisions use only the flags registered at the start of the
  // cycle, so a write into an empty FIFO can never be read in the same cycle.
  always_comb begin
    w_wr_acc    = bus.wr_en & ~r_full;
    w_rd_acc    = bus.rd_en & ~r_empty;
    w_wr_rej    = bus.wr_en & r_full;
    w_rd_rej    = bus.rd_en & r_empty;
    w_count_nxt = r_count + CW'(w_wr_acc) - CW'(w_rd_acc);
  end

  // Storage write; no reset so the array is left untouched by rst.
  always_ff @(posedge clk) begin
    if (rst && w_wr_acc) begin
      r_mem[r_wptr] <= bus.wr_data;
    end
  end

  // Pointers, occupancy and status flags; flags are derived from the next
  // count so they are valid the cycle after the causing edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      r_count        <= w_count_nxt;
      r_full         <= (w_count_nxt == C_DEPTH);
      r_almost_full  <= (w_count_nxt >= C_AF);
      r_empty        <= (w_count_nxt == '0);
      r_almost_empty <= (w_count_nxt <= C_AE);
    end
  end

  // Sticky error flags; a fresh error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (r_overflow  & ~bus.clr_err) | w_wr_rej;
      r_underflow <= (r_underflow & ~bus.clr_err) | w_rd_rej;
    end
  end

  // Read register captures the word being popped; it doubles as the stable
  // value shown in fall-through mode while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data <= '0;
    end else if (w_rd_acc) begin
      r_rd_data <= r_mem[r_rptr];
    end
  end

  // Output mapping; fall-through mode shows the head entry directly.
  always_comb begin
    if (FWFT != 0) begin
      bus.rd_data = r_empty ? r_rd_data : r_mem[r_rptr];
    end else begin
      bus.rd_data = r_rd_data;
    end
    bus.full         = r_full;
    bus.almost_full  = r_almost_full;
    bus.empty        = r_empty;
    bus.almost_empty = r_almost_empty;
    bus.count        = r_count;
    bus.overflow     = r_overflow;
    bus.underflow    = r_underflow;
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: one registered-read and one fall-through
// instance receive identical stimulus and are compared against a queue model.
module tb_sync_fifo_param;

  localparam int W  = 8;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus0 ();
  sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus1 ();

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0))
    u_reg (.clk(clk), .rst(rst), .bus(bus0));
  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1))
    u_fwft (.clk(clk), .rst(rst), .bus(bus1));

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, sticky bits, last popped word.
  logic [W-1:0] mq[$];
  bit           m_ovf;
  bit           m_udf;
  logic [W-1:0] m_last;

  typedef struct {
    bit           rstn;
    bit           wr;
    bit           rd;
    bit           clr;
    logic [W-1:0] din;
    int           cnt;
    bit           full;
    bit           empty;
    bit           ovf;
    bit           udf;
    logic [W-1:0] rd0;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit rstn, input bit wr, input logic [W-1:0] din,
                            input bit rd, input bit clr);
    bit was_full;
    bit was_empty;
    if (!rstn) begin
      mq.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_last = '0;
    end else begin
      was_full  = (mq.size() == D);
      was_empty = (mq.size() == 0);
      if (rd && !was_empty) m_last = mq.pop_front();
      if (wr && !was_full)  mq.push_back(din);
      m_ovf = (m_ovf && !clr) || (wr && was_full);
      m_udf = (m_udf && !clr) || (rd && was_empty);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, "_count0"}, 32'(bus0.count), n);
    chk({tag, "_count1"}, 32'(bus1.count), n);
    chk({tag, "_full"},   32'(bus0.full),  32'(n == D));
    chk({tag, "_empty"},  32'(bus0.empty), 32'(n == 0));
    chk({tag, "_af"},     32'(bus0.almost_full),  32'(n >= AF));
    chk({tag, "_ae"},     32'(bus0.almost_empty), 32'(n <= AE));
    chk({tag, "_empty1"}, 32'(bus1.empty), 32'(n == 0));
    chk({tag, "_ovf"},    32'(bus0.overflow),  32'(m_ovf));
    chk({tag, "_udf"},    32'(bus0.underflow), 32'(m_udf));
    chk({tag, "_ovf1"},   32'(bus1.overflow),  32'(m_ovf));
    chk({tag, "_udf1"},   32'(bus1.underflow), 32'(m_udf));
    chk({tag, "_rd_reg"}, 32'(bus0.rd_data), 32'(m_last));
    if (n > 0) chk({tag, "_rd_fwft"}, 32'(bus1.rd_data), 32'(mq[0]));
  endtask

  // One clock: drive inputs away from the edge, advance model, sample at +1.
  task automatic cyc(input bit rstn, input bit wr, input logic [W-1:0] din,
                     input bit rd, input bit clr, input string tag);
    rst          = rstn;
    bus0.wr_en   = wr;  bus1.wr_en   = wr;
    bus0.wr_data = din; bus1.wr_data = din;
    bus0.rd_en   = rd;  bus1.rd_en   = rd;
    bus0.clr_err = clr; bus1.clr_err = clr;
    @(posedge clk);
    model_edge(rstn, wr, din, rd, clr);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus0.wr_en = 1'b0; bus0.rd_en = 1'b0; bus0.clr_err = 1'b0; bus0.wr_data = '0;
    bus1.wr_en = 1'b0; bus1.rd_en = 1'b0; bus1.clr_err = 1'b0; bus1.wr_data = '0;
    m_ovf = 1'b0; m_udf = 1'b0; m_last = '0;

    // rstn wr rd clr din | cnt full empty ovf udf rd0
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h11};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h22, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h33};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].rstn, tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_cnt", i),   32'(bus0.count),     tbl[i].cnt);
      chk($sformatf("tbl%0d_full", i),  32'(bus0.full),      32'(tbl[i].full));
      chk($sformatf("tbl%0d_empty", i), 32'(bus0.empty),     32'(tbl[i].empty));
      chk($sformatf("tbl%0d_ovf", i),   32'(bus0.overflow),  32'(tbl[i].ovf));
      chk($sformatf("tbl%0d_udf", i),   32'(bus0.underflow), 32'(tbl[i].udf));
      chk($sformatf("tbl%0d_rd", i),    32'(bus0.rd_data),   32'(tbl[i].rd0));
    end

    // Fill to full, then one rejected write.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "fill_rst");
    for (int k = 0; k < D; k++) begin
      cyc(1'b1, 1'b1, W'(k), 1'b0, 1'b0, "fill");
      chk("fill_af",   32'(bus0.almost_full), 32'((k + 1) >= 14));
      chk("fill_full", 32'(bus0.full),        32'((k + 1) == 16));
    end
    chk("full_count", 32'(bus0.count), 32'd16);
    cyc(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, "ovf_wr");
    chk("ovf_set", 32'(bus0.overflow), 32'd1);
    chk("ovf_count", 32'(bus0.count), 32'd16);

    // Drain in order, then one rejected read.
    for (int k = 0; k < D; k++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "drain");
      chk("drain_data", 32'(bus0.rd_data), k);
    end
    chk("drain_empty", 32'(bus0.empty), 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "udf_rd");
    chk("udf_set", 32'(bus0.underflow), 32'd1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, "clr");

    // Hold occupancy at 8 with simultaneous push/pop across several wraps.
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b1, W'(8'h80 + k), 1'b0, 1'b0, "pre8");
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, 1'b1, W'(8'h40 + k), 1'b1, 1'b0, "steady");
      chk("steady_cnt", 32'(bus0.count), 32'd8);
    end

    // Fall-through single word appears without a read request.
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, "ft_rst");
    cyc(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, "ft_wr");
    chk("ft_data",  32'(bus1.rd_data), 32'hA5);
    chk("ft_empty", 32'(bus1.empty),   32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "ft_pop");
    chk("ft_pop_empty", 32'(bus1.empty), 32'd1);

    // Reset with ten entries stored discards them.
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b1, W'(8'hC0 + k), 1'b0, 1'b0, "pre10");
    chk("pre10_cnt", 32'(bus0.count), 32'd10);
    cyc(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, "mid_rst");
    chk("mid_rst_cnt",   32'(bus0.count),   32'd0);
    chk("mid_rst_empty", 32'(bus0.empty),   32'd1);
    chk("mid_rst_rd",    32'(bus0.rd_data), 32'd0);
    cyc(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, "post_wr");
    cyc(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, "post_rd");
    chk("post_rd_data", 32'(bus0.rd_data), 32'h77);

    // Random traffic, alternating fill-biased and drain-biased windows.
    for (int i = 0; i < 3000; i++) begin
      int  pw;
      bit  wr, rd, clr, rstn;
      pw   = (((i / 150) % 2) == 0) ? 75 : 25;
      wr   = ($urandom_range(0, 99) < pw);
      rd   = ($urandom_range(0, 99) < (100 - pw));
      clr  = ($urandom_range(0, 19) == 0);
      rstn = ($urandom_range(0, 299) != 0);
      cyc(rstn, wr, W'($urandom), rd, clr, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter WIDTH, 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, 16, number of entries; power of two, >=2.
REQ-003 Parameter AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL.
REQ-004 Parameter AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL.
REQ-005 Parameter FWFT, 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-low.
REQ-008 wr_en  input  1  write request.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 rd_en  input  1  read (pop) request.
REQ-011 rd_data  output  WIDTH  read data.
REQ-012 full, almost_full, empty, almost_empty  output  1 each  registered status flags.
REQ-013 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 overflow, underflow  output  1 each  sticky error flags.
REQ-015 clr_err  input  1  clears overflow and underflow.

Function
REQ-016 Write accepted iff wr_en=1 and full=0 at the clock edge; word stored at write pointer, pointer increments modulo DEPTH.
REQ-017 Read accepted iff rd_en=1 and empty=0 at the clock edge; read pointer increments modulo DEPTH.
REQ-018 Acceptance uses flag values at the start of the cycle; no same-cycle write-to-read bypass.
REQ-019 Simultaneous accepted write and read: count unchanged, both pointers advance.
REQ-020 Full with wr_en=1 and rd_en=1: read accepted, write rejected, overflow set.
REQ-021 Empty with wr_en=1 and rd_en=1: write accepted, read rejected, underflow set.
REQ-022 count = count + accepted_write - accepted_read each cycle; never exceeds DEPTH or underflows 0.
REQ-023 full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_LEVEL), almost_empty=(count<=AE_LEVEL); all computed from next count and registered, so valid the cycle after the causing edge.
REQ-024 Rejected write (wr_en=1, full=1) sets overflow; rejected read (rd_en=1, empty=1) sets underflow.
REQ-025 overflow/underflow remain 1 until clr_err=1; a new error in the same cycle as clr_err leaves the flag set.
REQ-026 FWFT=0: rd_data updates to popped word one cycle after accepted read; holds last value otherwise.
REQ-027 FWFT=1: rd_data presents head entry whenever empty=0, valid the cycle after empty deasserts; accepted read advances to next entry the following cycle; value undefined-but-stable when empty=1.
REQ-028 Pointers use DEPTH-entry wrap with no gap; wrap from DEPTH-1 to 0 is seamless across any number of passes.

Reset
REQ-029 rst=0 at a rising edge: both pointers 0, count 0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rd_data=0.
REQ-030 Reset mid-operation discards all stored entries; storage array is not cleared; wr_en/rd_en ignored while rst=0.
REQ-031 First operation accepted on the first edge with rst=1.

Verification
REQ-032 WIDTH=8, DEPTH=16: write 0x00..0x0F back-to-back -> full=1 after 16th write, count=16, almost_full=1 from count 14; 17th write -> overflow=1, data unchanged.
REQ-033 From full, read 16 words -> rd_data sequence 0x00..0x0F (FWFT=0, one-cycle latency), empty=1, count=0; extra read -> underflow=1.
REQ-034 Sustained simultaneous wr/rd for 40 cycles at count=8 -> count stays 8, output order matches input across pointer wrap.
REQ-035 Empty, wr_en=1 and rd_en=1 same cycle -> write stored, count=1, underflow=1; clr_err pulse -> underflow=0.
REQ-036 FWFT=1: single write 0xA5 -> rd_data=0xA5 with empty=0 next cycle, no rd_en needed; pop -> empty=1.
REQ-037 Fill to count=10, assert rst=0 one cycle -> all REQ-029 values, subsequent write/read returns new data only.
